// File: rtl/slice_chi_iota_engine_if.sv
// Bus between the chi/iota round-step engine and its state memory / controller.
interface slice_chi_iota_engine_if #(
  parameter int unsigned PAGE_W  = 6,
  parameter int unsigned SLICE_W = 25,
  parameter int unsigned RC_W    = 64
);
  logic               start;
  logic [RC_W-1:0]    rc;
  logic               en_iota;
  logic [SLICE_W-1:0] mem_out;
  logic [PAGE_W-1:0]  page;
  logic [SLICE_W-1:0] data;
  logic               write;
  logic               busy;
  logic               done;

  modport master (
    input  start, rc, en_iota, mem_out,
    output page, data, write, busy, done
  );

  modport slave (
    output start, rc, en_iota, mem_out,
    input  page, data, write, busy, done
  );
endinterface

// File: rtl/slice_chi_iota_engine.sv
// Walks all slice pages once per start, writing chi (and optionally iota) of each
// slice back to the state memory, one page per clock.
module slice_chi_iota_engine #(
  parameter int unsigned PAGES   = 64,
  parameter int unsigned SLICE_W = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  slice_chi_iota_engine_if.master  bus
);
  localparam int unsigned PAGE_W = $clog2(PAGES);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PAGE_W-1:0]  page_q,  page_d;
  logic [PAGES-1:0]   rc_q,    rc_d;
  logic               iota_q,  iota_d;
  logic               write_q, write_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [SLICE_W-1:0] data_c;

  // Slice-local transform: each 5-bit row is independent; iota touches lane (0,0) only.
  always_comb begin
    data_c = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        data_c[5*y + x] = bus.mem_out[5*y + x] ^
                          (~bus.mem_out[5*y + ((x + 1) % 5)] & bus.mem_out[5*y + ((x + 2) % 5)]);
      end
    end
    if (iota_q) begin
      data_c[0] = data_c[0] ^ rc_q[page_q];
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    rc_d    = rc_q;
    iota_d  = iota_q;
    write_d = write_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        page_d = '0;
        if (bus.start) begin
          state_d = RUN;
          rc_d    = bus.rc;
          iota_d  = bus.en_iota;
          write_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (page_q == LAST_PAGE) begin
          state_d = DONE;
          page_d  = '0;
          write_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          page_d = page_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        page_d  = '0;
        write_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      rc_q    <= '0;
      iota_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      rc_q    <= rc_d;
      iota_q  <= iota_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.page  = page_q;
  assign bus.data  = data_c;
  assign bus.write = write_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_slice_chi_iota_engine.sv
// Scoreboard bench for slice_chi_iota_engine with a behavioural memory and row-level chi model.
module tb_slice_chi_iota_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slice_chi_iota_engine_if #(.PAGE_W(6), .SLICE_W(25), .RC_W(64)) bus ();

  slice_chi_iota_engine #(.PAGES(64), .SLICE_W(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [24:0] mem     [64];
  logic [24:0] ref_mem [64];

  assign bus.mem_out = mem[bus.page];
  always @(posedge clk) begin
    if (bus.write) mem[bus.page] <= bus.data;
  end

  typedef struct {
    int          page;
    logic [24:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Row view: out = row ^ (~rotr(row,1) & rotr(row,2)) over 5-bit rows.
  function automatic logic [24:0] ref_step(input logic [24:0] a, input logic [63:0] rcv,
                                           input bit en, input int p);
    logic [24:0] o;
    int row, r1, r2, outrow;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      row    = int'((a >> (5*y)) & 25'h1F);
      r1     = ((row >> 1) | (row << 4)) & 31;
      r2     = ((row >> 2) | (row << 3)) & 31;
      outrow = (row ^ (~r1 & r2)) & 31;
      o      = o | (25'(outrow) << (5*y));
    end
    if (en && rcv[p]) o = o ^ 25'h1;
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.page), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_page", 64'(bus.page), 64'(e.page));
        check("write_data", 64'(bus.data), 64'(e.data));
      end
    end
    if (bus.done) done_cnt++;
  end

  task automatic load_mem(input int mode);
    for (int p = 0; p < 64; p++) begin
      case (mode)
        0:       mem[p] = 25'h0;
        1:       mem[p] = 25'h1FFFFFF;
        default: mem[p] = 25'($urandom) & 25'h1FFFFFF;
      endcase
      ref_mem[p] = mem[p];
    end
  endtask

  // rst_at > 0: rst sampled at the edge ending cycle rst_at, so pages 0..rst_at-1 get written.
  task automatic do_pass(input logic [63:0] rcv, input bit en, input int rst_at, input bit poke);
    int nw;
    int d0;
    exp_t e;
    nw = (rst_at > 0) ? rst_at : 64;
    d0 = done_cnt;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rc      = rcv;
    bus.en_iota = en;
    for (int p = 0; p < nw; p++) begin
      e.page = p;
      e.data = ref_step(ref_mem[p], rcv, en, p);
      ref_mem[p] = e.data;
      exp_q.push_back(e);
    end
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (poke && cyc == 10) bus.start = 1'b1;
      if (poke && cyc == 11) bus.start = 1'b0;
      if (poke && cyc == 20) begin
        bus.rc      = {$urandom, $urandom};
        bus.en_iota = ~en;
      end
      if (rst_at > 0) begin
        if (cyc <= rst_at) check("busy_run", 64'(bus.busy), 64'd1);
        if (cyc == rst_at) rst = 1'b1;
        if (cyc == rst_at + 1) begin
          check("rst_write", 64'(bus.write), 64'd0);
          check("rst_page", 64'(bus.page), 64'd0);
          check("rst_busy", 64'(bus.busy), 64'd0);
          rst = 1'b0;
        end
      end else if (cyc == 1 || cyc == 64 || cyc == 65 || cyc == 66 || cyc % 16 == 0) begin
        check("busy", 64'(bus.busy), 64'(cyc <= 64));
        check("write", 64'(bus.write), 64'(cyc <= 64));
        check("done", 64'(bus.done), 64'(cyc == 65));
      end
    end
    check("done_count", 64'(done_cnt - d0), 64'((rst_at > 0) ? 0 : 1));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    for (int p = 0; p < 64; p++) check("mem_final", 64'(mem[p]), 64'(ref_mem[p]));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.rc      = '0;
    bus.en_iota = 1'b0;
    load_mem(2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_page", 64'(bus.page), 64'd0);
    check("reset_write", 64'(bus.write), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_data", 64'(bus.data), 64'(ref_step(mem[0], 64'd0, 1'b0, 0)));
    rst = 1'b0;
    @(negedge clk);

    load_mem(0);
    do_pass(64'd0, 1'b0, 0, 1'b0);

    load_mem(0);
    mem[5] = 25'h0000001; ref_mem[5] = mem[5];
    mem[7] = 25'h0000002; ref_mem[7] = mem[7];
    do_pass({$urandom, $urandom}, 1'b0, 0, 1'b0);
    check("page5_const", 64'(mem[5]), 64'h9);
    check("page7_const", 64'(mem[7]), 64'h12);

    load_mem(1);
    do_pass(64'h8000000000000001, 1'b1, 0, 1'b0);
    check("page0_iota", 64'(mem[0]), 64'h1FFFFFE);
    check("page63_iota", 64'(mem[63]), 64'h1FFFFFE);
    check("page1_keep", 64'(mem[1]), 64'h1FFFFFF);

    load_mem(2);
    do_pass({$urandom, $urandom}, 1'b1, 0, 1'b1);

    load_mem(2);
    do_pass({$urandom, $urandom}, 1'b1, 29, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.rc = '1;
    bus.en_iota = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rststart_write", 64'(bus.write), 64'd0);
      check("rststart_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
    end

    for (int k = 0; k < 3; k++) begin
      load_mem(2);
      do_pass({$urandom, $urandom}, 1'($urandom), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
